// File: rtl/count_sequencer.sv
// count_sequencer: start/stop/reload control for an 8-bit parallel-load up-counter.
// Optional one-entry pending-command queue enabled by defining COUNT_SEQ_QUEUE_EN.
module count_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] start_value,
  input  logic       start_mode,
  input  logic       stop,
  input  logic       hold,
  input  logic [7:0] cnt_q,
  output logic       cnt_load,
  output logic       cnt_enable,
  output logic [7:0] cnt_d,
  output logic       tc_pulse,
  output logic [7:0] tc_total,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0] state;
  logic [7:0] value;
  logic       mode;
  logic       q_full;
  logic [7:0] q_value;
  logic       q_mode;
  logic       accept;
  logic       in_run;
  logic       tc_hit;

  assign in_run     = (state == RUN);
  assign busy       = (state != IDLE);
  assign accept     = start_valid & start_ready;
  assign cnt_enable = in_run & ~hold & ~stop;
  assign tc_hit     = cnt_enable & (cnt_q == 8'hFF);
  assign cnt_load   = (state == LOAD) | (tc_hit & (mode | q_full));
  assign cnt_d      = (tc_hit & q_full) ? q_value : value;

`ifdef COUNT_SEQ_QUEUE_EN
  assign start_ready = (state == IDLE) | (in_run & ~q_full);

  // A command accepted on a one-shot terminal count is taken directly by the FSM, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_full  <= 1'b0;
      q_value <= 8'h00;
      q_mode  <= 1'b0;
    end else if (in_run && stop) begin
      q_full <= 1'b0;
    end else if (tc_hit && q_full) begin
      q_full <= 1'b0;
    end else if (in_run && accept && !(tc_hit && !mode)) begin
      q_full  <= 1'b1;
      q_value <= start_value;
      q_mode  <= start_mode;
    end
  end
`else
  assign start_ready = (state == IDLE);
  assign q_full      = 1'b0;
  assign q_value     = 8'h00;
  assign q_mode      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      value    <= 8'h00;
      mode     <= 1'b0;
      tc_pulse <= 1'b0;
      tc_total <= 8'h00;
    end else begin
      tc_pulse <= tc_hit;
      if (tc_hit && (tc_total != 8'hFF))
        tc_total <= tc_total + 8'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            value    <= start_value;
            mode     <= start_mode;
            tc_total <= 8'h00;
            state    <= LOAD;
          end
        end
        LOAD: state <= stop ? IDLE : RUN;
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (tc_hit) begin
            if (q_full) begin
              value <= q_value;
              mode  <= q_mode;
            end else if (!mode) begin
              if (accept) begin
                value <= start_value;
                mode  <= start_mode;
                state <= LOAD;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
